// File: rtl/tl_ul_core_master_if.sv
// rtl/tl_ul_core_master_if.sv - TileLink-UL A/D channel bundle shared by master and slave
//
// Purpose : carries the TL-UL A (request) and D (response) channels.
// Modports: master_ul drives A and d_ready; slave_ul drives D and a_ready.
// Widths  : 32-bit address/data, 4-bit byte mask, 8-bit source ID.
interface tilelink;
   logic        a_valid;
   logic        a_ready;
   logic [2:0]  a_opcode;
   logic [2:0]  a_param;
   logic [1:0]  a_size;
   logic [7:0]  a_source;
   logic [31:0] a_address;
   logic [3:0]  a_mask;
   logic [31:0] a_data;
   logic        a_corrupt;

   logic        d_valid;
   logic        d_ready;
   logic [2:0]  d_opcode;
   logic [7:0]  d_source;
   logic [31:0] d_data;
   logic        d_error;

   modport master_ul (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      input  a_ready,
      input  d_valid, d_opcode, d_source, d_data, d_error,
      output d_ready
   );

   modport slave_ul (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      output a_ready,
      output d_valid, d_opcode, d_source, d_data, d_error,
      input  d_ready
   );
endinterface

// File: rtl/tl_ul_core_master.sv
// rtl/tl_ul_core_master.sv - single-outstanding core-to-TileLink-UL load/store master
//
// Purpose : accepts one core load/store at a time, issues it as a TL-UL A beat,
//           waits for the matching D beat and returns a one-cycle response.
// Ports   : clk_i, reset_i (sync, active-high)
//           req_valid/req_ready/req_write/req_addr/req_size/req_wdata - core request
//           resp_valid/resp_rdata/resp_error                          - core response
//           tilelink (master_ul)                                       - TL-UL A/D channels
module tl_ul_core_master #(
   parameter logic [7:0] SOURCE_ID = 8'd0
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   tilelink.master_ul  tilelink
);

   localparam logic [1:0] MEM_ACCESS_SIZE_BYTE = 2'd0;
   localparam logic [1:0] MEM_ACCESS_SIZE_HALF = 2'd1;

   localparam logic [2:0] OP_PUT_FULL_DATA    = 3'd0;
   localparam logic [2:0] OP_PUT_PARTIAL_DATA = 3'd1;
   localparam logic [2:0] OP_GET              = 3'd4;
   localparam logic [2:0] OP_ACCESS_ACK       = 3'd0;
   localparam logic [2:0] OP_ACCESS_ACK_DATA  = 3'd1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND_A = 2'd1,
      WAIT_D = 2'd2,
      RESP   = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        error_q, error_d;

   logic        misaligned;
   logic [31:0] d_shifted;
   logic [31:0] d_lane;
   logic [2:0]  d_opcode_exp;

   // Word-or-larger encodings (bit 1 set) need a 4-byte aligned address.
   assign misaligned = ((req_size == MEM_ACCESS_SIZE_HALF) && req_addr[0]) ||
                       (req_size[1] && (req_addr[1:0] != 2'b00));

   // Load data arrives on its natural byte lanes; bring it down to bit 0 and trim.
   assign d_shifted = tilelink.d_data >> {addr_q[1:0], 3'b000};

   always_comb begin
      d_lane = d_shifted;
      case (size_q)
         MEM_ACCESS_SIZE_BYTE: d_lane = {24'h0, d_shifted[7:0]};
         MEM_ACCESS_SIZE_HALF: d_lane = {16'h0, d_shifted[15:0]};
         default:              d_lane = d_shifted;
      endcase
   end

   assign d_opcode_exp = write_q ? OP_ACCESS_ACK : OP_ACCESS_ACK_DATA;

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      addr_d  = addr_q;
      size_d  = size_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      error_d = error_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               addr_d  = req_addr;
               size_d  = req_size;
               wdata_d = req_wdata;
               rdata_d = 32'h0;
               // A misaligned request never reaches the bus; it is answered locally.
               error_d = misaligned;
               state_d = misaligned ? RESP : SEND_A;
            end
         end
         SEND_A: begin
            if (tilelink.a_ready) state_d = WAIT_D;
         end
         WAIT_D: begin
            if (tilelink.d_valid) begin
               rdata_d = write_q ? 32'h0 : d_lane;
               error_d = tilelink.d_error ||
                         (tilelink.d_source != SOURCE_ID) ||
                         (tilelink.d_opcode != d_opcode_exp);
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         addr_q  <= 32'h0;
         size_q  <= 2'd0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_error = (state_q == RESP) && error_q;
   assign resp_rdata = rdata_q;

   // A fields come only from captured registers, so they stay stable under backpressure.
   assign tilelink.a_valid   = (state_q == SEND_A);
   assign tilelink.a_opcode  = !write_q ? OP_GET :
                               (size_q[1] ? OP_PUT_FULL_DATA : OP_PUT_PARTIAL_DATA);
   assign tilelink.a_param   = 3'd0;
   assign tilelink.a_size    = size_q;
   assign tilelink.a_source  = SOURCE_ID;
   assign tilelink.a_address = addr_q;
   assign tilelink.a_corrupt = 1'b0;

   always_comb begin
      tilelink.a_mask = 4'b1111;
      tilelink.a_data = wdata_q;
      case (size_q)
         MEM_ACCESS_SIZE_BYTE: begin
            tilelink.a_mask = 4'b0001 << addr_q[1:0];
            tilelink.a_data = {4{wdata_q[7:0]}};
         end
         MEM_ACCESS_SIZE_HALF: begin
            tilelink.a_mask = 4'b0011 << {addr_q[1], 1'b0};
            tilelink.a_data = {2{wdata_q[15:0]}};
         end
         default: begin
            tilelink.a_mask = 4'b1111;
            tilelink.a_data = wdata_q;
         end
      endcase
   end

   assign tilelink.d_ready = (state_q == WAIT_D);

endmodule

// File: tb/tb_tl_ul_core_master.sv
// tb/tb_tl_ul_core_master.sv - randomized self-checking bench for tl_ul_core_master
module tb_tl_ul_core_master;
   localparam logic [7:0] SRC = 8'd5;
   localparam logic [2:0] OP_GET = 3'd4, OP_PUT_FULL = 3'd0, OP_PUT_PART = 3'd1;
   localparam logic [2:0] OP_ACK = 3'd0, OP_ACK_DATA = 3'd1;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;

   int checks = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   tilelink tl_bus ();

   tl_ul_core_master #(.SOURCE_ID(SRC)) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_size   (req_size),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_error (resp_error),
      .tilelink   (tl_bus)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One complete transaction: the slave stalls A for a_stall cycles and D for d_stall cycles.
   task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [1:0] size, input logic [31:0] wdata,
                          input logic [31:0] ddata, input logic [7:0] dsrc,
                          input logic [2:0] dop, input logic derr,
                          input int a_stall, input int d_stall);
      logic        mis, eerr, got_err, ready_after;
      logic [3:0]  emask;
      logic [31:0] edata, erdata, got_rdata;
      logic [2:0]  eop;
      logic [63:0] lane_mask;
      logic [84:0] a_first, a_now;
      int          n, a_cnt, d_cnt, resp_n, resp_pulses, bad_ready, bad_stable, bad_misc, bits, shift;

      // Reference expectations computed straight from the access rules.
      mis = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
      case (size)
         2'd0:    begin emask = 4'b0001 << addr[1:0];           edata = {4{wdata[7:0]}};  end
         2'd1:    begin emask = addr[1] ? 4'b1100 : 4'b0011;   edata = {2{wdata[15:0]}}; end
         default: begin emask = 4'b1111;                        edata = wdata;            end
      endcase
      eop = !wr ? OP_GET : ((size == 2'd2) ? OP_PUT_FULL : OP_PUT_PART);
      bits = 8 * (1 << size);
      shift = 8 * int'(addr[1:0]);
      lane_mask = (64'd1 << bits) - 64'd1;
      if (mis) begin
         erdata = 32'h0;
         eerr = 1'b1;
      end else begin
         erdata = wr ? 32'h0 : ((ddata >> shift) & lane_mask[31:0]);
         eerr = derr || (dsrc != SRC) || (dop != (wr ? OP_ACK : OP_ACK_DATA));
      end

      @(negedge clk_i);
      check_val({tag, " ready_before"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size; req_wdata = wdata;
      @(posedge clk_i);

      n = 0; resp_n = -1; a_cnt = 0; d_cnt = 0; resp_pulses = 0;
      bad_ready = 0; bad_stable = 0; bad_misc = 0;
      got_rdata = 32'h0; got_err = 1'b0; ready_after = 1'b0; a_first = '0;
      while (n < 60 && (resp_n < 0 || n < resp_n + 2)) begin
         @(negedge clk_i);
         n++;
         if (n == 1) begin
            // Scramble the request inputs to prove the block works from its captured copy.
            req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
            req_write = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 2));
         end
         if (resp_valid) begin
            resp_pulses++;
            if (resp_n < 0) begin
               resp_n = n; got_rdata = resp_rdata; got_err = resp_error;
            end
         end else if (resp_error) bad_misc++;
         if (resp_n < 0 && req_ready) bad_ready++;
         if (resp_n > 0 && n == resp_n + 1) ready_after = req_ready;
         if (tl_bus.a_valid && tl_bus.d_ready) bad_misc++;
         if (tl_bus.a_valid) begin
            a_cnt++;
            a_now = {tl_bus.a_opcode, tl_bus.a_param, tl_bus.a_size, tl_bus.a_source,
                     tl_bus.a_address, tl_bus.a_mask, tl_bus.a_data, tl_bus.a_corrupt};
            if (a_cnt == 1) begin
               a_first = a_now;
               check_val({tag, " a_opcode"}, 32'(tl_bus.a_opcode), 32'(eop));
               check_val({tag, " a_mask"}, 32'(tl_bus.a_mask), 32'(emask));
               check_val({tag, " a_data"}, tl_bus.a_data, edata);
               check_val({tag, " a_address"}, tl_bus.a_address, addr);
               check_val({tag, " a_misc"},
                         {16'h0, tl_bus.a_source, tl_bus.a_param, tl_bus.a_size, tl_bus.a_corrupt, 2'b0},
                         {16'h0, SRC, 3'd0, size, 1'b0, 2'b0});
            end else if (a_now !== a_first) bad_stable++;
            tl_bus.a_ready = (a_cnt > a_stall);
         end else begin
            tl_bus.a_ready = 1'($urandom_range(0, 1));
         end
         if (tl_bus.d_ready) begin
            d_cnt++;
            tl_bus.d_valid = (d_cnt > d_stall);
            tl_bus.d_opcode = dop; tl_bus.d_source = dsrc;
            tl_bus.d_data = ddata; tl_bus.d_error = derr;
         end else begin
            // Stray D beats outside WAIT_D must be ignored.
            tl_bus.d_valid = 1'($urandom_range(0, 1));
            tl_bus.d_opcode = 3'($urandom); tl_bus.d_source = 8'($urandom);
            tl_bus.d_data = $urandom; tl_bus.d_error = 1'($urandom_range(0, 1));
         end
      end
      tl_bus.a_ready = 1'b0;
      tl_bus.d_valid = 1'b0;

      if (mis) begin
         check_val({tag, " no_a_beat"}, 32'(a_cnt), 32'd0);
         check_val({tag, " latency"}, 32'(resp_n), 32'd1);
      end else begin
         check_val({tag, " a_cycles"}, 32'(a_cnt), 32'(a_stall + 1));
         check_val({tag, " a_stable"}, 32'(bad_stable), 32'd0);
         check_val({tag, " latency"}, 32'(resp_n), 32'(3 + a_stall + d_stall));
      end
      check_val({tag, " resp_pulses"}, 32'(resp_pulses), 32'd1);
      check_val({tag, " resp_rdata"}, got_rdata, erdata);
      check_val({tag, " resp_error"}, 32'(got_err), 32'(eerr));
      check_val({tag, " ready_low"}, 32'(bad_ready), 32'd0);
      check_val({tag, " ready_after"}, 32'(ready_after), 32'd1);
      check_val({tag, " protocol"}, 32'(bad_misc), 32'd0);
   endtask

   // Start a load, hold it in SEND_A (phase 0) or WAIT_D (phase 1), then pulse reset.
   task automatic reset_mid(input string tag, input int phase);
      int n, pulses, bad;
      logic reached;
      @(negedge clk_i);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h200; req_size = 2'd2; req_wdata = 32'h0;
      tl_bus.a_ready = 1'b0; tl_bus.d_valid = 1'b0;
      reached = 1'b0; n = 0;
      while (!reached && n < 20) begin
         @(negedge clk_i);
         n++;
         req_valid = 1'b0;
         if (phase == 0) reached = tl_bus.a_valid;
         else begin
            reached = tl_bus.d_ready;
            tl_bus.a_ready = tl_bus.a_valid;
         end
      end
      check_val({tag, " reached"}, 32'(reached), 32'd1);
      tl_bus.a_ready = 1'b0;
      reset_i = 1'b1;
      @(negedge clk_i);
      reset_i = 1'b0;
      check_val({tag, " a_valid"}, 32'(tl_bus.a_valid), 32'd0);
      check_val({tag, " d_ready"}, 32'(tl_bus.d_ready), 32'd0);
      check_val({tag, " req_ready"}, 32'(req_ready), 32'd1);
      check_val({tag, " resp_rdata"}, resp_rdata, 32'h0);
      pulses = 0; bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (resp_valid) pulses++;
         if (tl_bus.a_valid || !req_ready) bad++;
         tl_bus.d_valid = 1'($urandom_range(0, 1));
         @(negedge clk_i);
      end
      tl_bus.d_valid = 1'b0;
      check_val({tag, " no_resp"}, 32'(pulses), 32'd0);
      check_val({tag, " stays_idle"}, 32'(bad), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       wr, derr;
      logic [1:0] sz;
      logic [7:0] dsrc;
      logic [2:0] dop;

      reset_i = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
      req_size = 2'd0; req_wdata = 32'h0;
      tl_bus.a_ready = 1'b0; tl_bus.d_valid = 1'b0; tl_bus.d_opcode = 3'd0;
      tl_bus.d_source = 8'd0; tl_bus.d_data = 32'h0; tl_bus.d_error = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check_val("rst req_ready", 32'(req_ready), 32'd1);
      check_val("rst a_valid", 32'(tl_bus.a_valid), 32'd0);
      check_val("rst d_ready", 32'(tl_bus.d_ready), 32'd0);
      check_val("rst resp_valid", 32'(resp_valid), 32'd0);
      check_val("rst resp_rdata", resp_rdata, 32'h0);
      check_val("rst resp_error", 32'(resp_error), 32'd0);
      reset_i = 1'b0;

      run_txn("load_word",  1'b0, 32'h100, 2'd2, 32'h0,        32'hDEADBEEF, SRC, OP_ACK_DATA, 1'b0, 0, 0);
      run_txn("store_byte", 1'b1, 32'h103, 2'd0, 32'h000000A5, 32'h0,        SRC, OP_ACK,      1'b0, 0, 0);
      run_txn("load_half",  1'b0, 32'h102, 2'd1, 32'h0,        32'h1234ABCD, SRC, OP_ACK_DATA, 1'b0, 0, 0);
      run_txn("backpress",  1'b1, 32'h40,  2'd2, 32'hCAFEF00D, 32'h0,        SRC, OP_ACK,      1'b0, 5, 3);
      run_txn("misaligned", 1'b0, 32'h101, 2'd2, 32'h0,        32'h0,        SRC, OP_ACK_DATA, 1'b0, 0, 0);
      run_txn("d_error",    1'b0, 32'h104, 2'd2, 32'h0,        32'h11223344, SRC, OP_ACK_DATA, 1'b1, 0, 0);
      run_txn("bad_source", 1'b1, 32'h108, 2'd1, 32'h5678,     32'h0,        SRC + 8'd1, OP_ACK, 1'b0, 1, 1);
      run_txn("bad_opcode", 1'b0, 32'h10C, 2'd0, 32'h0,        32'h99887766, SRC, OP_ACK,      1'b0, 0, 2);
      reset_mid("rst_wait_d", 1);
      reset_mid("rst_send_a", 0);

      for (int t = 0; t < 40; t++) begin
         wr   = 1'($urandom_range(0, 1));
         sz   = 2'($urandom_range(0, 2));
         dsrc = ($urandom_range(0, 7) == 0) ? 8'($urandom) : SRC;
         dop  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : (wr ? OP_ACK : OP_ACK_DATA);
         derr = ($urandom_range(0, 7) == 0);
         run_txn($sformatf("rand%0d", t), wr, $urandom, sz, $urandom, $urandom,
                 dsrc, dop, derr, $urandom_range(0, 4), $urandom_range(0, 4));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
